// File: rtl/rec_mes_buf.sv
// Receive-side CAN message buffer: a small show-ahead FIFO of complete frames
// with a valid/ack pop handshake, head bus-ID tap and sticky overflow flag.
module rec_mes_buf #(
    parameter int DW    = 76,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_rec_in,
    input  logic          rec_valid_in,
    input  logic          rec_ack,
    input  logic          clr_ovf,
    output logic [DW-1:0] data_rec_out,
    output logic [4:0]    data_rec_bus,
    output logic          rec_valid_out,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          overflow,
    output logic [AW:0]   msg_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, wr_en, drop;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        empty = (cnt_q == '0);
        full  = (cnt_q == FULL_CNT);
        // An ack against an empty buffer is not a pop; a pop frees a slot
        // in time for a same-cycle write, so a full buffer can still accept.
        pop   = rec_ack & ~empty;
        wr_en = rec_valid_in & (~full | pop);
        drop  = rec_valid_in & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = (ovf_q & ~clr_ovf) | drop;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; stale
    // entries are never visible because the output is gated by the count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_rec_in;
    end

    assign data_rec_out  = empty ? '0 : mem_q[rd_ptr_q];
    assign data_rec_bus  = data_rec_out[20:16];
    assign rec_valid_out = ~empty;
    assign fifo_empty    = empty;
    assign fifo_full     = full;
    assign overflow      = ovf_q;
    assign msg_cnt       = cnt_q;

endmodule

// File: tb/tb_rec_mes_buf.sv
// Directed self-checking bench for rec_mes_buf: table-driven vectors plus
// hand sequences for wrap-around ordering and asynchronous mid-run reset.
module tb_rec_mes_buf;

    localparam int DW    = 76;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_rec_in;
    logic          rec_valid_in;
    logic          rec_ack;
    logic          clr_ovf;
    logic [DW-1:0] data_rec_out;
    logic [4:0]    data_rec_bus;
    logic          rec_valid_out;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow;
    logic [AW:0]   msg_cnt;

    int checks = 0;
    int errors = 0;

    rec_mes_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_rec_in   (data_rec_in),
        .rec_valid_in  (rec_valid_in),
        .rec_ack       (rec_ack),
        .clr_ovf       (clr_ovf),
        .data_rec_out  (data_rec_out),
        .data_rec_bus  (data_rec_bus),
        .rec_valid_out (rec_valid_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .overflow      (overflow),
        .msg_cnt       (msg_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] b;
        logic       ack;
        logic       clr;
        logic       exp_valid;
        logic [7:0] exp_b;
        int         exp_cnt;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[16];

    // Frame whose bus field (bits 20:16) and low byte are derived from b.
    function automatic logic [DW-1:0] frame(input logic [7:0] b);
        return {4'h9, 48'hDEAD_BEEF_1234, 3'b000, b[4:0], 8'h00, b};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic v, input logic [DW-1:0] d,
                               input int cnt, input logic ovf);
        logic [DW-1:0] ed;
        ed = v ? d : '0;
        check({tag, " valid"}, DW'(rec_valid_out), DW'(v));
        check({tag, " data"},  data_rec_out, ed);
        check({tag, " bus"},   DW'(data_rec_bus), DW'(ed[20:16]));
        check({tag, " cnt"},   DW'(msg_cnt), DW'(cnt));
        check({tag, " full"},  DW'(fifo_full), DW'(cnt == DEPTH));
        check({tag, " empty"}, DW'(fifo_empty), DW'(cnt == 0));
        check({tag, " ovf"},   DW'(overflow), DW'(ovf));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic wr, input logic [DW-1:0] d, input logic ack, input logic clr);
        rec_valid_in = wr;
        data_rec_in  = d;
        rec_ack      = ack;
        clr_ovf      = clr;
        @(posedge clk);
        #1;
        rec_valid_in = 1'b0;
        rec_ack      = 1'b0;
        clr_ovf      = 1'b0;
    endtask

    logic [DW-1:0] first_frame;
    logic [DW-1:0] q[$];
    logic [DW-1:0] head;
    logic [4:0]    bus_exp;

    initial begin
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1, 1'b0};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 2, 1'b0};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 3, 1'b0};
        vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 4, 1'b0};
        vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 4, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 4, 1'b0};
        vecs[6]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 4, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 4, 1'b0};
        vecs[8]  = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 8'h02, 4, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 3, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 2, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h06, 1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        vecs[14] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};

        rst          = 1'b0;
        rec_valid_in = 1'b0;
        rec_ack      = 1'b0;
        clr_ovf      = 1'b0;
        data_rec_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 1'b0, '0, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, one-cycle latency, then pop back to empty.
        first_frame = 76'h0_0000_0000_0015_0ABC;
        cyc(1'b1, first_frame, 1'b0, 1'b0);
        check_state("single", 1'b1, first_frame, 1, 1'b0);
        bus_exp = 5'h15;
        check("single bus id", DW'(data_rec_bus), DW'(bus_exp));
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_state("single pop", 1'b0, '0, 0, 1'b0);

        // Fill, overflow, clear, set-wins, full write+pop, drain, empty corner cases.
        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].wr, frame(vecs[i].b), vecs[i].ack, vecs[i].clr);
            check_state($sformatf("vec%0d", i), vecs[i].exp_valid, frame(vecs[i].exp_b),
                        vecs[i].exp_cnt, vecs[i].exp_ovf);
        end

        // Interleaved writes and pops with 1..3 entries resident; crosses pointer wrap.
        for (int i = 0; i < 10; i++) begin
            int tgt;
            cyc(1'b1, frame(8'h20 + 8'(i)), 1'b0, 1'b0);
            q.push_back(frame(8'h20 + 8'(i)));
            check_state($sformatf("wrap wr%0d", i), 1'b1, q[0], q.size(), 1'b0);
            tgt = $urandom_range(1, 3);
            while (q.size() > tgt) begin
                head = q.pop_front();
                check($sformatf("wrap head%0d", i), data_rec_out, head);
                cyc(1'b0, '0, 1'b1, 1'b0);
                check_state($sformatf("wrap pop%0d", i), 1'b1, q[0], q.size(), 1'b0);
            end
        end
        while (q.size() > 0) begin
            head = q.pop_front();
            check("drain head", data_rec_out, head);
            cyc(1'b0, '0, 1'b1, 1'b0);
            check_state("drain", q.size() > 0, (q.size() > 0) ? q[0] : '0, q.size(), 1'b0);
        end

        // Three entries plus a sticky overflow, then reset asserted between edges.
        for (int i = 0; i < 4; i++) cyc(1'b1, frame(8'h40 + 8'(i)), 1'b0, 1'b0);
        cyc(1'b1, frame(8'h50), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_state("pre-reset", 1'b1, frame(8'h41), 3, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state("async reset", 1'b0, '0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, frame(8'hAA), 1'b0, 1'b0);
        check_state("post-reset", 1'b1, frame(8'hAA), 1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_state("post-reset pop", 1'b0, '0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rec_mes_buf.md
Name: rec_mes_buf

Overview:
- Receive-side message buffer: the counterpart of the transmit message buffer.
- Accepts complete 76-bit CAN frames from the CAN receiver/bus-side logic and queues them in a small FIFO.
- Presents them to the SCB / Object Dictionary side with a valid/ack handshake.
- Also exposes the bus-ID field of the head message and overflow status.

Parameters:
- DW, 76, message width in bits.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- data_rec_in  input  DW  frame received from CAN bus side.
- rec_valid_in  input  1  one-cycle strobe: data_rec_in holds a complete frame.
- rec_ack  input  1  consumer pops the head message this cycle.
- clr_ovf  input  1  clears the sticky overflow flag.
- data_rec_out  output  DW  head-of-FIFO message to SCB/OD side.
- data_rec_bus  output  5  bus ID of the head message, equal to data_rec_out[20:16].
- rec_valid_out  output  1  head message is valid.
- fifo_full  output  1  DEPTH entries stored.
- fifo_empty  output  1  no entries stored.
- overflow  output  1  sticky: a frame was dropped.
- msg_cnt  output  AW+1  number of stored entries, 0..DEPTH.

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr, rd_ptr and msg_cnt = 0.
  - overflow = 0, fifo_empty = 1, fifo_full = 0, rec_valid_out = 0.
  - data_rec_out = 0, data_rec_bus = 0.
  - Memory contents need not be cleared.
- Reset mid-operation discards all queued frames. The first frame after reset release is stored normally.
- Write:
  - When rec_valid_in=1 and (fifo_full=0 or pop this cycle), mem[wr_ptr] <= data_rec_in and wr_ptr increments modulo DEPTH.
- Pop:
  - pop = rec_ack & rec_valid_out. On pop, rd_ptr increments modulo DEPTH.
  - rec_ack while rec_valid_out=0 is ignored: no pointer or count change.
- Show-ahead (first-word-fall-through):
  - data_rec_out = mem[rd_ptr] whenever fifo_empty=0; otherwise 0.
  - A frame written into an empty FIFO at edge N appears on data_rec_out, with rec_valid_out=1, after edge N (one-cycle latency).
- rec_valid_out = ~fifo_empty.
- fifo_empty = (msg_cnt==0); fifo_full = (msg_cnt==DEPTH).
- msg_cnt:
  - +1 on write only, -1 on pop only.
  - Unchanged on simultaneous write and pop.
  - Never exceeds DEPTH and never underflows.
- Full with write and pop in the same cycle: both happen, msg_cnt stays DEPTH, no overflow.
- Empty with rec_valid_in and rec_ack in the same cycle: the ack is ignored and the write is accepted. msg_cnt becomes 1.
- Overflow:
  - rec_valid_in=1, fifo_full=1 and no pop → frame dropped; memory and pointers unchanged; overflow <= 1 at the next edge.
  - clr_ovf clears overflow. If clr_ovf and a new drop occur in the same cycle, set wins.
- Pointer wrap: both pointers wrap DEPTH-1 → 0. Ordering is strictly FIFO across the wrap.
- data_rec_bus is always data_rec_out[20:16], with no extra register stage. It is 0 when empty.
- All state registers are updated only on posedge clk, or asynchronously by reset.

Test Plan:
- Reset then single frame:
  - Stimulus: write 76'h0_0000_0000_0015_0ABC with rec_valid_in for 1 cycle.
  - Response: the next cycle shows rec_valid_out=1, data_rec_out equal to that value, data_rec_bus=5'h15, msg_cnt=1. Pulse rec_ack → fifo_empty=1 and data_rec_out=0 the next cycle.
- Fill and order:
  - Stimulus: write frames with low bytes 0x01..0x04 in consecutive cycles.
  - Response: fifo_full=1, msg_cnt=4. Popping 4 times returns 0x01, 0x02, 0x03, 0x04 in order, then fifo_empty=1.
- Overflow:
  - Stimulus: with the FIFO full, write 0x05.
  - Response: overflow=1, msg_cnt=4, and 0x05 is never read back. Pulse clr_ovf → overflow=0. Check the same-cycle clr_ovf plus drop case → overflow stays 1.
- Simultaneous events:
  - Stimulus: FIFO full, write 0x06 and ack in the same cycle.
  - Response: no overflow, msg_cnt=4, and the head advances. Stimulus: FIFO empty, write and ack together → msg_cnt=1 and the frame is preserved.
- Wrap-around:
  - Stimulus: 10 interleaved write/pop pairs with a random 1–3 entry occupancy.
  - Response: the read sequence matches the write sequence exactly, and no spurious full or empty flags occur.
- Reset mid-operation:
  - Stimulus: with 3 entries stored, assert rst between clock edges.
  - Response: all outputs go to their reset values immediately (asynchronously). After release, a new frame 0xAA is the first one read.
